// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operating modes.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_universal_if.sv
// Control/data bundle for shift_reg_universal; rotate exists only when
// SHIFT_REG_ROTATE_EN is defined.
interface shift_reg_universal_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
);

  mode_t                      mode;
  logic                       serial_in;
  logic [WIDTH-1:0]           par_in;
`ifdef SHIFT_REG_ROTATE_EN
  logic                       rotate;
`endif
  logic [WIDTH-1:0]           Q;
  logic                       serial_out;
  logic [$clog2(WIDTH)-1:0]   bit_cnt;
  logic                       word_valid;

  modport master (
    output mode, serial_in, par_in,
`ifdef SHIFT_REG_ROTATE_EN
    output rotate,
`endif
    input  Q, serial_out, bit_cnt, word_valid
  );

  modport slave (
    input  mode, serial_in, par_in,
`ifdef SHIFT_REG_ROTATE_EN
    input  rotate,
`endif
    output Q, serial_out, bit_cnt, word_valid
  );

endinterface : shift_reg_universal_if

// File: rtl/shift_reg_universal_bit_counter.sv
// Counts shifts within a serial word and pulses word_valid when the
// WIDTH-th shift of the word lands.
module shift_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     word_valid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else if (inc) begin
      if (bit_cnt == LAST) begin
        bit_cnt    <= '0;
        word_valid <= 1'b1;
      end else begin
        bit_cnt    <= bit_cnt + 1'b1;
        word_valid <= 1'b0;
      end
    end else begin
      word_valid <= 1'b0;
    end
  end

endmodule : shift_bit_counter

// File: rtl/shift_reg_universal.sv
// Universal shift register (hold / shift right / shift left / load) with a
// word counter. Define SHIFT_REG_ROTATE_EN to add the rotate input.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                  clk,
  input logic                  rst,
  shift_reg_universal_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             shr_fill;
  logic             shl_fill;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    shr_fill = bus.serial_in;
    shl_fill = bus.serial_in;
`ifdef SHIFT_REG_ROTATE_EN
    if (bus.rotate) begin
      shr_fill = q_r[0];
      shl_fill = q_r[WIDTH-1];
    end
`endif
  end

  always_comb begin
    q_next = q_r;
    unique case (bus.mode)
      MODE_HOLD: q_next = q_r;
      MODE_SHR:  q_next = {shr_fill, q_r[WIDTH-1:1]};
      MODE_SHL:  q_next = {q_r[WIDTH-2:0], shl_fill};
      MODE_LOAD: q_next = bus.par_in;
      default:   q_next = q_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_r <= RST_VAL;
    else      q_r <= q_next;
  end

  assign bus.Q = q_r;

  // The bit that would leave on the next shift in the current direction.
  assign bus.serial_out = (bus.mode == MODE_SHR) ? q_r[0] : q_r[WIDTH-1];

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .inc        ((bus.mode == MODE_SHR) || (bus.mode == MODE_SHL)),
    .clr        (bus.mode == MODE_LOAD),
    .bit_cnt    (bus.bit_cnt),
    .word_valid (bus.word_valid)
  );

endmodule : shift_reg_universal

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised universal shift register with hold, shift-right, shift-left and parallel-load modes. It succeeds the fixed 4-bit serial-in register. It adds a bit counter that flags each completed serial word, so it can be used directly as a serialiser or deserialiser in lab datapaths (UART-style framing, LED chains, serial-to-parallel capture).

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2).
- RST_VAL, 0, value loaded into Q on reset (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mode  in  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- serial_in  in  1  bit inserted on shift: MSB side on shift right, LSB side on shift left.
- par_in  in  WIDTH  parallel load data.
- rotate  in  1  rotate select. Present only with SHIFT_REG_ROTATE_EN.
- Q  out  WIDTH  register contents.
- serial_out  out  1  bit that leaves on the next shift: Q[0] when mode=01, otherwise Q[WIDTH-1]. Combinational from Q and mode.
- bit_cnt  out  $clog2(WIDTH)  shifts accumulated in the current word.
- word_valid  out  1  one-cycle pulse: WIDTH shifts have completed since the last word boundary.

## Operation
- rst low forces the following immediately, independent of clk: Q=RST_VAL, bit_cnt=0, word_valid=0.
- Behaviour on each rising clk with rst high:
  - 00: Q, bit_cnt held; word_valid=0.
  - 01: Q <= {serial_in, Q[WIDTH-1:1]}; counter advances.
  - 10: Q <= {Q[WIDTH-2:0], serial_in}; counter advances.
  - 11: Q <= par_in; bit_cnt <= 0; word_valid <= 0.
- Counter advance:
  - If bit_cnt == WIDTH-1: bit_cnt <= 0 and word_valid <= 1.
  - Otherwise: bit_cnt <= bit_cnt+1 and word_valid <= 0.
- Mixing left and right shifts within one word is legal. Both directions count toward the same word.
- Load during a partial word discards the partial count. No word_valid is generated for the discarded bits.

## Timing
- Q, bit_cnt and word_valid are registered. Each updates one edge after the qualifying mode is sampled.
- word_valid goes high in the same cycle that Q holds the complete word (after the WIDTH-th shift). It lasts exactly one cycle unless the next edge also completes a word. That case is impossible for WIDTH≥2.
- Continuous shifting produces one word_valid every WIDTH cycles. The first pulse comes WIDTH cycles after reset release.
- rst asserted mid-word: all state clears asynchronously. The first edge after release counts as bit 0.
- rst deasserting coincident with a clk edge: that edge is ignored. Clock operation resumes on the following edge.
- mode, serial_in and par_in must be stable around the rising clk edge. There is no internal synchroniser.

## Configuration
- SHIFT_REG_ROTATE_EN defined:
  - The rotate port exists.
  - With rotate=1, shifts use the outgoing bit instead of serial_in. Shift right uses Q[0] into the MSB; shift left uses Q[WIDTH-1] into the LSB.
  - Rotates count toward word_valid like any shift.
- SHIFT_REG_ROTATE_EN undefined: the rotate port is absent and shifts always take serial_in.

## Structure
- Package shift_reg_pkg holds:
  - Mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - The 2-bit mode typedef.
- Sub-module shift_bit_counter holds:
  - Inputs: inc, clr, clk, rst.
  - Outputs: bit_cnt, word_valid.
  - Parameter: WIDTH.
  - It is instantiated once. inc = mode is 01 or 10; clr = mode is 11.

## Test plan
- WIDTH=4, RST_VAL=4'hA. Assert rst low mid-cycle → Q=4'hA, bit_cnt=0, word_valid=0 before the next edge.
- Shift right serial_in sequence 1,0,1,1 from Q=0 → Q=4'b1101 after 4 edges; word_valid high only in that cycle; bit_cnt=0.
- Shift left the same sequence from 0 → Q=4'b1011; serial_out tracks Q[3] each cycle.
- Shift right 2 bits, then load par_in=4'h5 → Q=4'h5, bit_cnt=0. Four further shifts are needed before word_valid; no pulse appears after 2.
- Continuous shift for 12 cycles → word_valid pulses at cycles 4, 8 and 12. Holding mode=00 between shifts freezes both bit_cnt and Q.
- With SHIFT_REG_ROTATE_EN: Q=4'b0001, rotate=1, shift right once → 4'b1000. Four rotations return Q=4'b0001 with one word_valid.
